// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage RV32I core.
//
// Keeps a shadow valid bit per stage (ID/EX/MEM/WB). It detects RAW and
// load-use hazards and applies branch/jump redirect flushes and LSU freezes.
// It drives the pipeline-register enables and flushes, and registers the
// forwarding selects for the EX operand muxes.
//
// Parameters
//   FWD_EN : 1 = forwarding, 0 = interlock-only (stall on any EX/MEM RAW).
//   CNT_W  : width of the saturating stall/flush counters.
// Ports
//   i_clk, i_reset                   : clock, async active-high reset
//   i_if_vld                         : fetch presents an instruction
//   i_id_rs{1,2}_addr/_use           : ID source registers and use flags
//   i_{ex,mem,wb}_rd_addr/_wren      : destination register per stage
//   i_ex_is_load, i_ex_redirect      : EX load flag, taken branch/jump
//   i_lsu_busy                       : MEM cannot complete this cycle
//   o_pc_en .. o_mem_wb_en           : pipeline register enables
//   o_if_id_flush, o_id_ex_flush     : bubble insertion
//   o_fwd_a_sel, o_fwd_b_sel         : 00 regfile, 01 EX/MEM, 10 MEM/WB
//   o_insn_vld                       : WB holds a valid instruction
//   o_stall_cnt, o_flush_cnt         : saturating event counters
//
// Handshake: none. Every control output is a level for the current cycle.
// Enables and flushes are combinational from state and inputs.
// Selects, o_insn_vld and the counters take effect one clock later.
module hazard_ctrl #(
  parameter int unsigned FWD_EN = 1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_if_vld,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic             i_id_rs1_use,
  input  logic             i_id_rs2_use,
  input  logic [4:0]       i_ex_rd_addr,
  input  logic [4:0]       i_mem_rd_addr,
  input  logic [4:0]       i_wb_rd_addr,
  input  logic             i_ex_rd_wren,
  input  logic             i_mem_rd_wren,
  input  logic             i_wb_rd_wren,
  input  logic             i_ex_is_load,
  input  logic             i_ex_redirect,
  input  logic             i_lsu_busy,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_id_ex_en,
  output logic             o_ex_mem_en,
  output logic             o_mem_wb_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic [1:0]       o_fwd_a_sel,
  output logic [1:0]       o_fwd_b_sel,
  output logic             o_insn_vld,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam bit LP_FWD = (FWD_EN != 0);

  localparam logic [1:0] MODE_RUN      = 2'd0;
  localparam logic [1:0] MODE_FREEZE   = 2'd1;
  localparam logic [1:0] MODE_REDIRECT = 2'd2;
  localparam logic [1:0] MODE_STALL    = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_v_id, r_v_ex, r_v_mem, r_v_wb;
  logic [1:0]       r_fwd_a, r_fwd_b;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic       w_ex_w, w_mem_w;
  logic       w_a_ex, w_b_ex, w_a_mem, w_b_mem;
  logic       w_hazard;
  logic [1:0] w_mode;
  logic [1:0] w_fwd_a_nxt, w_fwd_b_nxt;

  // x0 writes never produce a hazard or a forward.
  // WB needs no qualification because the regfile is write-first.
  assign w_ex_w  = r_v_ex  & i_ex_rd_wren  & (i_ex_rd_addr  != 5'd0);
  assign w_mem_w = r_v_mem & i_mem_rd_wren & (i_mem_rd_addr != 5'd0);

  assign w_a_ex  = r_v_id & i_id_rs1_use & (i_id_rs1_addr == i_ex_rd_addr)  & w_ex_w;
  assign w_b_ex  = r_v_id & i_id_rs2_use & (i_id_rs2_addr == i_ex_rd_addr)  & w_ex_w;
  assign w_a_mem = r_v_id & i_id_rs1_use & (i_id_rs1_addr == i_mem_rd_addr) & w_mem_w;
  assign w_b_mem = r_v_id & i_id_rs2_use & (i_id_rs2_addr == i_mem_rd_addr) & w_mem_w;

  assign w_hazard = LP_FWD ? ((w_a_ex | w_b_ex) & i_ex_is_load)
                           : (w_a_ex | w_b_ex | w_a_mem | w_b_mem);

  // EX match takes priority over MEM: it is the younger producer.
  assign w_fwd_a_nxt = !LP_FWD ? 2'b00 : (w_a_ex ? 2'b01 : (w_a_mem ? 2'b10 : 2'b00));
  assign w_fwd_b_nxt = !LP_FWD ? 2'b00 : (w_b_ex ? 2'b01 : (w_b_mem ? 2'b10 : 2'b00));

  // Priority: freeze > redirect > stall > run.
  always_comb begin
    w_mode = MODE_RUN;
    if (i_lsu_busy)                   w_mode = MODE_FREEZE;
    else if (r_v_ex && i_ex_redirect) w_mode = MODE_REDIRECT;
    else if (w_hazard)                w_mode = MODE_STALL;
  end

  // While reset is held the pipeline free-runs with no bubbles,
  // even if the LSU reports busy.
  always_comb begin
    o_pc_en       = 1'b1;
    o_if_id_en    = 1'b1;
    o_id_ex_en    = 1'b1;
    o_ex_mem_en   = 1'b1;
    o_mem_wb_en   = 1'b1;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    if (!i_reset) begin
      case (w_mode)
        MODE_FREEZE: begin
          o_pc_en     = 1'b0;
          o_if_id_en  = 1'b0;
          o_id_ex_en  = 1'b0;
          o_ex_mem_en = 1'b0;
          o_mem_wb_en = 1'b0;
        end
        MODE_REDIRECT: begin
          o_if_id_flush = 1'b1;
          o_id_ex_flush = 1'b1;
        end
        MODE_STALL: begin
          o_pc_en       = 1'b0;
          o_if_id_en    = 1'b0;
          o_id_ex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_v_id      <= 1'b0;
      r_v_ex      <= 1'b0;
      r_v_mem     <= 1'b0;
      r_v_wb      <= 1'b0;
      r_fwd_a     <= 2'b00;
      r_fwd_b     <= 2'b00;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (w_mode)
        MODE_FREEZE: begin
          if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
        MODE_REDIRECT: begin
          r_v_id  <= 1'b0;
          r_v_ex  <= 1'b0;
          r_v_mem <= r_v_ex;
          r_v_wb  <= r_v_mem;
          r_fwd_a <= 2'b00;
          r_fwd_b <= 2'b00;
          if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
        MODE_STALL: begin
          // The ID instruction stays put; a bubble enters EX.
          r_v_ex  <= 1'b0;
          r_v_mem <= r_v_ex;
          r_v_wb  <= r_v_mem;
          r_fwd_a <= 2'b00;
          r_fwd_b <= 2'b00;
          if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
        default: begin
          r_v_id  <= i_if_vld;
          r_v_ex  <= r_v_id;
          r_v_mem <= r_v_ex;
          r_v_wb  <= r_v_mem;
          r_fwd_a <= w_fwd_a_nxt;
          r_fwd_b <= w_fwd_b_nxt;
        end
      endcase
    end
  end

  assign o_fwd_a_sel = r_fwd_a;
  assign o_fwd_b_sel = r_fwd_b;
  assign o_insn_vld  = r_v_wb;
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl.
// One instance runs with forwarding and one without; both share the stimulus.
// The observed vector is
//   {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
//    if_id_flush, id_ex_flush, fwd_a, fwd_b, insn_vld}.
module tb_hazard_ctrl;

  localparam logic [6:0] RUN7 = 7'b1111100;
  localparam logic [6:0] STL7 = 7'b0011101;
  localparam logic [6:0] RDR7 = 7'b1111111;
  localparam logic [6:0] FRZ7 = 7'b0000000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       if_vld, rs1_use, rs2_use, ex_wren, mem_wren, wb_wren;
  logic       ex_ld, ex_redir, lsu_busy;
  logic [4:0] rs1, rs2, ex_rd, mem_rd, wb_rd;

  logic        d1_pc, d1_ifid, d1_idex, d1_exmem, d1_memwb, d1_flifid, d1_flidex, d1_vld;
  logic [1:0]  d1_fa, d1_fb;
  logic [31:0] d1_scnt, d1_fcnt;
  logic        d0_pc, d0_ifid, d0_idex, d0_exmem, d0_memwb, d0_flifid, d0_flidex, d0_vld;
  logic [1:0]  d0_fa, d0_fb;
  logic [31:0] d0_scnt, d0_fcnt;

  hazard_ctrl #(.FWD_EN(1), .CNT_W(32)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_if_vld(if_vld),
    .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
    .i_id_rs1_use(rs1_use), .i_id_rs2_use(rs2_use),
    .i_ex_rd_addr(ex_rd), .i_mem_rd_addr(mem_rd), .i_wb_rd_addr(wb_rd),
    .i_ex_rd_wren(ex_wren), .i_mem_rd_wren(mem_wren), .i_wb_rd_wren(wb_wren),
    .i_ex_is_load(ex_ld), .i_ex_redirect(ex_redir), .i_lsu_busy(lsu_busy),
    .o_pc_en(d1_pc), .o_if_id_en(d1_ifid), .o_id_ex_en(d1_idex),
    .o_ex_mem_en(d1_exmem), .o_mem_wb_en(d1_memwb),
    .o_if_id_flush(d1_flifid), .o_id_ex_flush(d1_flidex),
    .o_fwd_a_sel(d1_fa), .o_fwd_b_sel(d1_fb), .o_insn_vld(d1_vld),
    .o_stall_cnt(d1_scnt), .o_flush_cnt(d1_fcnt)
  );

  hazard_ctrl #(.FWD_EN(0), .CNT_W(32)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_if_vld(if_vld),
    .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
    .i_id_rs1_use(rs1_use), .i_id_rs2_use(rs2_use),
    .i_ex_rd_addr(ex_rd), .i_mem_rd_addr(mem_rd), .i_wb_rd_addr(wb_rd),
    .i_ex_rd_wren(ex_wren), .i_mem_rd_wren(mem_wren), .i_wb_rd_wren(wb_wren),
    .i_ex_is_load(ex_ld), .i_ex_redirect(ex_redir), .i_lsu_busy(lsu_busy),
    .o_pc_en(d0_pc), .o_if_id_en(d0_ifid), .o_id_ex_en(d0_idex),
    .o_ex_mem_en(d0_exmem), .o_mem_wb_en(d0_memwb),
    .o_if_id_flush(d0_flifid), .o_id_ex_flush(d0_flidex),
    .o_fwd_a_sel(d0_fa), .o_fwd_b_sel(d0_fb), .o_insn_vld(d0_vld),
    .o_stall_cnt(d0_scnt), .o_flush_cnt(d0_fcnt)
  );

  logic [11:0] obs1, obs0;
  assign obs1 = {d1_pc, d1_ifid, d1_idex, d1_exmem, d1_memwb, d1_flifid, d1_flidex, d1_fa, d1_fb, d1_vld};
  assign obs0 = {d0_pc, d0_ifid, d0_idex, d0_exmem, d0_memwb, d0_flifid, d0_flidex, d0_fa, d0_fb, d0_vld};

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];
  string       tag_q[$];
  int checks = 0;
  int errors = 0;

  task automatic pop_check(input bit use0);
    logic [11:0] e;
    logic [11:0] o;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = use0 ? obs0 : obs1;
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s dut%0d obs=%b exp=%b", t, use0 ? 0 : 1, o, e);
    end
  endtask

  // Push expectation, let the cycle's combinational outputs settle,
  // compare on the falling edge, then advance past the next rising edge.
  task automatic step(input string tag, input bit use0, input logic [11:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    pop_check(use0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string tag, input bit use0, input logic [11:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    pop_check(use0);
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, o, e);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drv(input logic ifv,
                     input logic [4:0] a1, input logic [4:0] a2, input logic u1, input logic u2,
                     input logic [4:0] exr, input logic exw, input logic ld, input logic rd_r,
                     input logic [4:0] mr, input logic mw,
                     input logic [4:0] wr, input logic ww, input logic busy);
    if_vld = ifv; rs1 = a1; rs2 = a2; rs1_use = u1; rs2_use = u2;
    ex_rd = exr; ex_wren = exw; ex_ld = ld; ex_redir = rd_r;
    mem_rd = mr; mem_wren = mw; wb_rd = wr; wb_wren = ww; lsu_busy = busy;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_pipe();
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    // In reset: enables read 1 even with the LSU busy.
    check_now("rst_out1", 0, {RUN7, 2'b00, 2'b00, 1'b0});
    check_now("rst_out0", 1, {RUN7, 2'b00, 2'b00, 1'b0});
    chk_cnt("rst_scnt", d1_scnt, 0);
    chk_cnt("rst_fcnt", d1_fcnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();

    // A: add x5 ; sub x6,x5,x1 with forwarding.
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("a0", 0, {RUN7, 2'b00, 2'b00, 1'b0});
    drv(1, 2, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("a1", 0, {RUN7, 2'b00, 2'b00, 1'b0});
    drv(0, 5, 1, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    step("a2_no_stall", 0, {RUN7, 2'b00, 2'b00, 1'b0});
    drv(0, 0, 0, 0, 0, 6, 1, 0, 0, 5, 1, 0, 0, 0);
    step("a3_fwd_ex", 0, {RUN7, 2'b01, 2'b00, 1'b0});
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 1, 5, 1, 0);
    step("a4", 0, {RUN7, 2'b00, 2'b00, 1'b1});
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 1, 0);
    step("a5", 0, {RUN7, 2'b00, 2'b00, 1'b1});
    chk_cnt("a_scnt", d1_scnt, 0);
    chk_cnt("a_fcnt", d1_fcnt, 0);

    // B: lw x7 ; add x8,x7,x7 load-use.
    reset_pipe();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("b0", 0, {RUN7, 2'b00, 2'b00, 1'b0});
    drv(1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("b1", 0, {RUN7, 2'b00, 2'b00, 1'b0});
    drv(1, 7, 7, 1, 1, 7, 1, 1, 0, 0, 0, 0, 0, 0);
    step("b2_stall", 0, {STL7, 2'b00, 2'b00, 1'b0});
    chk_cnt("b_scnt1", d1_scnt, 1);
    drv(1, 7, 7, 1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    step("b3_resume", 0, {RUN7, 2'b00, 2'b00, 1'b0});
    drv(0, 0, 0, 1, 0, 8, 1, 0, 0, 0, 0, 7, 1, 0);
    step("b4_fwd_mem", 0, {RUN7, 2'b10, 2'b10, 1'b1});
    chk_cnt("b_scnt2", d1_scnt, 1);

    // C: redirect in EX with a concurrent load-use pattern in ID.
    reset_pipe();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("c0", 0, {RUN7, 2'b00, 2'b00, 1'b0});
    drv(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("c1", 0, {RUN7, 2'b00, 2'b00, 1'b0});
    drv(1, 7, 0, 1, 0, 7, 1, 1, 1, 0, 0, 0, 0, 0);
    step("c2_redirect", 0, {RDR7, 2'b00, 2'b00, 1'b0});
    chk_cnt("c_fcnt", d1_fcnt, 1);
    chk_cnt("c_scnt", d1_scnt, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("c3", 0, {RUN7, 2'b00, 2'b00, 1'b0});
    step("c4_beq_wb", 0, {RUN7, 2'b00, 2'b00, 1'b1});
    step("c5_bubble", 0, {RUN7, 2'b00, 2'b00, 1'b0});
    step("c6_bubble", 0, {RUN7, 2'b00, 2'b00, 1'b0});
    step("c7_target", 0, {RUN7, 2'b00, 2'b00, 1'b1});

    // D: add x5 ; lw x7,0(x5) ; add x8,x7,x7 with LSU busy over the stall.
    reset_pipe();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("d0", 0, {RUN7, 2'b00, 2'b00, 1'b0});
    step("d1", 0, {RUN7, 2'b00, 2'b00, 1'b0});
    drv(1, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    step("d2", 0, {RUN7, 2'b00, 2'b00, 1'b0});
    drv(1, 7, 7, 1, 1, 7, 1, 1, 0, 5, 1, 0, 0, 1);
    step("d3_frz", 0, {FRZ7, 2'b01, 2'b00, 1'b0});
    step("d4_frz", 0, {FRZ7, 2'b01, 2'b00, 1'b0});
    step("d5_frz", 0, {FRZ7, 2'b01, 2'b00, 1'b0});
    chk_cnt("d_scnt3", d1_scnt, 3);
    drv(1, 7, 7, 1, 1, 7, 1, 1, 0, 5, 1, 0, 0, 0);
    step("d6_stall", 0, {STL7, 2'b01, 2'b00, 1'b0});
    chk_cnt("d_scnt4", d1_scnt, 4);
    drv(1, 7, 7, 1, 1, 0, 0, 0, 0, 7, 1, 5, 1, 0);
    step("d7", 0, {RUN7, 2'b00, 2'b00, 1'b1});
    drv(0, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 7, 1, 0);
    step("d8_fwd", 0, {RUN7, 2'b10, 2'b10, 1'b1});
    chk_cnt("d_scnt_end", d1_scnt, 4);

    // E: interlock-only instance, addi x1 ; addi x2,x1,1 ; x0 traffic.
    reset_pipe();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("e0", 1, {RUN7, 2'b00, 2'b00, 1'b0});
    drv(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("e1", 1, {RUN7, 2'b00, 2'b00, 1'b0});
    drv(1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step("e2_stall_ex", 1, {STL7, 2'b00, 2'b00, 1'b0});
    drv(1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    step("e3_stall_mem", 1, {STL7, 2'b00, 2'b00, 1'b0});
    chk_cnt("e_scnt2", d0_scnt, 2);
    drv(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step("e4_wb_ok", 1, {RUN7, 2'b00, 2'b00, 1'b1});
    drv(1, 0, 0, 1, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    step("e5", 1, {RUN7, 2'b00, 2'b00, 1'b0});
    drv(0, 0, 0, 1, 1, 0, 1, 0, 0, 2, 1, 0, 0, 0);
    step("e6_x0", 1, {RUN7, 2'b00, 2'b00, 1'b0});
    chk_cnt("e_scnt_x0", d0_scnt, 2);

    // F: asynchronous reset mid-stream, sampled without a clock edge.
    idle();
    check_now("f_pre", 1, {RUN7, 2'b00, 2'b00, 1'b1});
    #1;
    rst = 1'b1;
    lsu_busy = 1'b1;
    check_now("f_rst0", 1, {RUN7, 2'b00, 2'b00, 1'b0});
    check_now("f_rst1", 0, {RUN7, 2'b00, 2'b00, 1'b0});
    chk_cnt("f_scnt0", d0_scnt, 0);
    chk_cnt("f_fcnt1", d1_fcnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB). Tracks a shadow valid bit per stage, detects RAW and load-use hazards, applies branch/jump redirect flushes and LSU freezes, and generates all pipeline-register enables/flushes plus registered forwarding selects for the EX operand muxes. Its WB valid bit drives the core's `o_insn_vld` debug output; stall and flush counters are exposed for performance debug.

## Interface
- `FWD_EN`, 1: 1 = forwarding enabled; 0 = interlock-only (stall on every RAW hazard with EX or MEM).
- `CNT_W`, 32: width of the stall/flush counters.
- `i_clk`  in  1  core clock, all state on rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_if_vld`  in  1  fetch presents a real instruction to IF/ID this cycle.
- `i_id_rs1_addr`, `i_id_rs2_addr`  in  5  source registers of the instruction in ID.
- `i_id_rs1_use`, `i_id_rs2_use`  in  1  ID instruction reads rs1/rs2.
- `i_ex_rd_addr`, `i_mem_rd_addr`, `i_wb_rd_addr`  in  5  destination register per stage.
- `i_ex_rd_wren`, `i_mem_rd_wren`, `i_wb_rd_wren`  in  1  stage instruction writes rd.
- `i_ex_is_load`  in  1  EX instruction is a load.
- `i_ex_redirect`  in  1  EX resolved a taken branch/jump (PC redirect).
- `i_lsu_busy`  in  1  MEM stage cannot complete this cycle.
- `o_pc_en`, `o_if_id_en`, `o_id_ex_en`, `o_ex_mem_en`, `o_mem_wb_en`  out  1  register enables.
- `o_if_id_flush`, `o_id_ex_flush`  out  1  load a bubble into that register.
- `o_fwd_a_sel`, `o_fwd_b_sel`  out  2  EX operand source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result.
- `o_insn_vld`  out  1  WB stage holds a valid instruction.
- `o_stall_cnt`, `o_flush_cnt`  out  CNT_W  saturating event counters.

## Operation
- State: `v_id, v_ex, v_mem, v_wb`, registered fwd selects, two counters. Writes to rd=x0 never match.
- Qualified writers: `ex_w = v_ex & i_ex_rd_wren & rd!=0`; same for mem/wb.
- Match: `mA_ex = v_id & i_id_rs1_use & rs1==ex_rd & ex_w` (likewise rs2, MEM).
- Load-use hazard: FWD_EN=1: EX match with `i_ex_is_load`. FWD_EN=0: any EX or MEM match. WB never hazards (regfile is write-first).
- Mode priority, evaluated each cycle:
  - FREEZE (`i_lsu_busy`): all enables 0, no flushes; state held; stall_cnt +1.
  - REDIRECT (`v_ex & i_ex_redirect`): all enables 1, both flushes 1; next `v_id=0`, `v_ex=0`, fwd sels 00; flush_cnt +1. Concurrent hazard ignored.
  - STALL (hazard): `o_pc_en=0`, `o_if_id_en=0`, `o_id_ex_flush=1`, EX/MEM and MEM/WB enabled; next `v_ex=0`, `v_id` held, sels 00; stall_cnt +1.
  - RUN: all enables 1, no flush; valids shift: `v_id<=i_if_vld`, `v_ex<=v_id`, `v_mem<=v_ex`, `v_wb<=v_mem`.
- `v_mem<=v_ex`, `v_wb<=v_mem` also in REDIRECT and STALL.
- Forward select, computed in ID, registered when ID→EX advances (RUN): FWD_EN=1: EX match → 01, else MEM match → 10, else 00 (EX has priority). FWD_EN=0: always 00.
- Counters saturate at all-ones, never wrap.

## Timing
- Enables/flushes combinational from state and inputs, same cycle.
- Fwd selects, `o_insn_vld`, counters registered; 1-cycle latency.
- Reset (async, any time): all valids 0, sels 00, counters 0, `o_insn_vld=0`; enables read 1, flushes 0 while in reset.
- Load-use with FWD_EN=1 costs exactly 1 bubble; dependent then receives sel 10.
- FWD_EN=0: RAW on EX producer costs 2 bubbles, on MEM producer 1.
- Redirect costs 2 bubbles; `o_insn_vld` low for 2 cycles at WB.

## Test plan
- Back-to-back `add x5`; `sub x6,x5,x1` (FWD_EN=1) → no stall, `o_fwd_a_sel=01` one cycle after sub leaves ID; `o_stall_cnt=0`.
- `lw x7`; `add x8,x7,x7` → one cycle `o_pc_en=0`, `o_id_ex_flush=1`; then both sels 10; stall_cnt=1.
- Taken `beq` in EX with load-use hazard in ID same cycle → REDIRECT wins, both flushes 1, stall_cnt unchanged, flush_cnt=1, `o_insn_vld` 0 for 2 cycles.
- `i_lsu_busy` high 3 cycles during a stall → all enables 0, sels held, stall_cnt +3; pipeline resumes exactly where held.
- FWD_EN=0, `addi x1`; `addi x2,x1,1` → 2 stall cycles, sels stay 00; writes to x0 never stall.
- Assert `i_reset` mid-stream → next edge-free sample: `o_insn_vld=0`, counters 0, sels 00.
